// File: rtl/wb_commit_pkg.sv
// rtl/wb_commit_pkg.sv - shared load-size codes and writeback state encodings
package wb_commit_pkg;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/wb_commit_if.sv
// rtl/wb_commit_if.sv - commit-stage to writeback handover bundle
interface wb_commit_if #(
  parameter int DW   = 32,
  parameter int RFAW = 5
);
  logic            ec_valid;
  logic [31:0]     ec_pc;
  logic [DW-1:0]   ec_res;
  logic [DW-1:0]   ec_reorder_data;
  logic            ec_load;
  logic [1:0]      ec_load_size;
  logic            ec_load_signed;
  logic            ec_req_sent;
  logic            ec_wreg;
  logic [RFAW-1:0] ec_waddr;
  logic            ec_eret;
  logic            exc_oc;
  logic            wb_allowin;
  logic            wb_eret;
  logic            wb_fwd_pending;

  modport master (
    output ec_valid, ec_pc, ec_res, ec_reorder_data, ec_load, ec_load_size,
           ec_load_signed, ec_req_sent, ec_wreg, ec_waddr, ec_eret, exc_oc,
    input  wb_allowin, wb_eret, wb_fwd_pending
  );

  modport slave (
    input  ec_valid, ec_pc, ec_res, ec_reorder_data, ec_load, ec_load_size,
           ec_load_signed, ec_req_sent, ec_wreg, ec_waddr, ec_eret, exc_oc,
    output wb_allowin, wb_eret, wb_fwd_pending
  );
endinterface

// File: rtl/wb_commit_load_align.sv
// rtl/wb_commit_load_align.sv - selects the addressed byte/half of a load word and extends it
module wb_commit_load_align
  import wb_commit_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data,
  input  logic [1:0]    a,
  input  logic [1:0]    size,
  input  logic          sgn,
  output logic [DW-1:0] word
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (a)
      2'd1:    byte_v = data[15:8];
      2'd2:    byte_v = data[23:16];
      2'd3:    byte_v = data[31:24];
      default: byte_v = data[7:0];
    endcase
    half_v = a[1] ? data[31:16] : data[15:0];
    case (size)
      LS_BYTE: word = {{(DW-8){sgn & byte_v[7]}}, byte_v};
      LS_HALF: word = {{(DW-16){sgn & half_v[15]}}, half_v};
      default: word = data;
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - writeback stage: waits for load data, drains killed loads, writes the register file
module wb_commit
  import wb_commit_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RFAW = 5
) (
  input  logic            clk,
  input  logic            reset,
  wb_commit_if.slave      ec,
  input  logic            data_rvalid,
  input  logic [DW-1:0]   data_rdata,
  output logic            data_rready,
  output logic            rf_wen,
  output logic [RFAW-1:0] rf_waddr,
  output logic [DW-1:0]   rf_wdata,
  output logic [31:0]     wb_pc
);

  state_t          state;
  logic            ebuf_valid;
  logic [DW-1:0]   ebuf_data;
  logic [31:0]     pc_q;
  logic [RFAW-1:0] waddr_q;
  logic            wreg_q;
  logic            eret_q;
  logic [1:0]      addr_q;
  logic [1:0]      size_q;
  logic            sgn_q;
  logic [DW-1:0]   res_q;
  logic            wen_out_q;
  logic            eret_out_q;

  logic            in_wait;
  logic            rsp_take;
  logic            accept;
  logic            data_avail;
  logic            load_takes;
  logic            live_wen;
  logic [DW-1:0]   fill_data;
  logic [DW-1:0]   al_data;
  logic [1:0]      al_a;
  logic [1:0]      al_size;
  logic            al_sgn;
  logic [DW-1:0]   aligned;

  assign in_wait           = (state == ST_WAIT);
  assign data_rready       = in_wait || (state == ST_DRAIN) || !ebuf_valid;
  assign ec.wb_allowin     = (state == ST_EMPTY) || (state == ST_COMMIT);
  assign ec.wb_eret        = eret_out_q;
  assign ec.wb_fwd_pending = in_wait && wreg_q;

  assign rsp_take   = data_rvalid && data_rready;
  assign accept     = ec.ec_valid && ec.wb_allowin;
  assign data_avail = ebuf_valid || rsp_take;
  assign fill_data  = ebuf_valid ? ebuf_data : data_rdata;
  // A killed load only claims response data if it actually issued a request.
  assign load_takes = accept && ec.ec_load && (ec.ec_req_sent || !ec.exc_oc);
  assign live_wen   = ec.ec_wreg && (ec.ec_waddr != '0);

  // In WAIT the load's attributes are already latched; otherwise the accepting load's are live.
  assign al_data = in_wait ? data_rdata : fill_data;
  assign al_a    = in_wait ? addr_q : ec.ec_res[1:0];
  assign al_size = in_wait ? size_q : ec.ec_load_size;
  assign al_sgn  = in_wait ? sgn_q  : ec.ec_load_signed;

  wb_commit_load_align #(.DW(DW)) u_align (
    .data (al_data),
    .a    (al_a),
    .size (al_size),
    .sgn  (al_sgn),
    .word (aligned)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      ebuf_valid <= 1'b0;
      ebuf_data  <= '0;
      pc_q       <= '0;
      waddr_q    <= '0;
      wreg_q     <= 1'b0;
      eret_q     <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      res_q      <= '0;
      wen_out_q  <= 1'b0;
      eret_out_q <= 1'b0;
    end else begin
      wen_out_q  <= 1'b0;
      eret_out_q <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (rsp_take) begin
            state      <= ST_COMMIT;
            res_q      <= aligned;
            wen_out_q  <= wreg_q && (waddr_q != '0);
            eret_out_q <= eret_q;
          end
        end
        ST_DRAIN: begin
          if (rsp_take) state <= ST_EMPTY;
        end
        default: begin
          if (rsp_take && !load_takes) begin
            ebuf_valid <= 1'b1;
            ebuf_data  <= data_rdata;
          end else if (load_takes) begin
            ebuf_valid <= 1'b0;
          end
          state <= ST_EMPTY;
          if (accept) begin
            if (ec.exc_oc) begin
              if (ec.ec_load && ec.ec_req_sent && !data_avail) state <= ST_DRAIN;
            end else begin
              pc_q    <= ec.ec_pc;
              waddr_q <= ec.ec_waddr;
              wreg_q  <= ec.ec_wreg;
              eret_q  <= ec.ec_eret;
              addr_q  <= ec.ec_res[1:0];
              size_q  <= ec.ec_load_size;
              sgn_q   <= ec.ec_load_signed;
              if (ec.ec_load && !data_avail) begin
                state <= ST_WAIT;
              end else begin
                state      <= ST_COMMIT;
                res_q      <= ec.ec_load ? aligned : ec.ec_reorder_data;
                wen_out_q  <= live_wen;
                eret_out_q <= ec.ec_eret;
              end
            end
          end
        end
      endcase
    end
  end

  assign rf_wen   = wen_out_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = res_q;
  assign wb_pc    = pc_q;

endmodule

// File: doc/wb_commit.md
Name: wb_commit

Overview:
- Final writeback stage, directly downstream of the exception-commit stage.
- Registers each instruction the commit stage hands over.
- Waits for the load-data response where required, aligns and sign/zero-extends load data, and drives the register-file write port.
- Returns the eret-commit indication (wb_eret) and backpressure (wb_allowin) to the commit stage.
- Buffers one load response that arrives early and drains responses belonging to loads killed by an exception.

Parameters:
- DW, 32, datapath / register data width
- RFAW, 5, register-file address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ec_valid  in  1  commit stage holds a valid instruction
- ec_pc  in  32  PC of that instruction
- ec_res  in  32  ALU result / load effective address
- ec_reorder_data  in  32  non-load result (CP0 read data or ALU result)
- ec_load  in  1  instruction is a load
- ec_load_size  in  2  0=byte, 1=half, 2=word
- ec_load_signed  in  1  sign-extend sub-word load
- ec_req_sent  in  1  a data read request was issued for this load
- ec_wreg  in  1  instruction writes a GPR
- ec_waddr  in  RFAW  destination GPR
- ec_eret  in  1  instruction is eret
- exc_oc  in  1  commit stage is taking an exception this cycle; the instruction is killed
- data_rvalid  in  1  load response valid
- data_rdata  in  DW  load response data
- data_rready  out  1  block accepts a response this cycle
- wb_allowin  out  1  block accepts from the commit stage this cycle
- wb_eret  out  1  eret committing this cycle
- wb_fwd_pending  out  1  load to ec_waddr is outstanding; upstream must stall its consumers
- rf_wen  out  1  register-file write enable
- rf_waddr  out  RFAW  register-file write address
- rf_wdata  out  DW  register-file write data
- wb_pc  out  32  PC of the committing instruction (debug)

Behaviour:
- States: EMPTY, WAIT, DRAIN, COMMIT.
- Accept: accept = ec_valid && wb_allowin. wb_allowin = state in {EMPTY, COMMIT}.
- Early buffer: one entry (ebuf_valid, ebuf_data).
- data_rready = (state in {WAIT, DRAIN}) || !ebuf_valid.
- Response handshake: a response is taken when data_rvalid && data_rready.
- Priority of a taken response:
  - 1. DRAIN or WAIT consumes it.
  - 2. Otherwise, it is used directly by a load accepted the same cycle with ec_req_sent=1.
  - 3. Otherwise, it is written to the early buffer.
- On accept, killed (exc_oc=1):
  - Load with ec_req_sent=1: if ebuf_valid or a response is taken this cycle, discard that data and go to EMPTY; else go to DRAIN.
  - All other killed instructions: go to EMPTY, no write.
- On accept, live load: if ebuf_valid or a response is taken this cycle, go to COMMIT with that data and clear ebuf; else go to WAIT.
- On accept, live non-load: go to COMMIT with ec_reorder_data.
- WAIT: a taken response goes to COMMIT. DRAIN: a taken response goes to EMPTY.
- COMMIT: lasts exactly one cycle. Outputs in that cycle:
  - rf_wen = latched wreg && (latched waddr != 0)
  - rf_waddr = latched waddr, rf_wdata = latched result, wb_pc = latched pc
  - wb_eret = latched eret
  - Next state follows the accept rules above, else EMPTY.
- Latency:
  - Non-load accepted in cycle N: commits in N+1.
  - Load whose data is available at accept (ebuf or same cycle): commits in N+1.
  - Load whose response is taken in cycle M while in WAIT: commits in M+1.
- Load alignment, using a = latched ec_res[1:0]:
  - Byte: data[8a+7:8a].
  - Half: a[1] selects data[31:16] or data[15:0].
  - Word: data unchanged.
  - Sub-word results are extended per the signed flag.
  - Misaligned addresses never arrive live, because they raise exceptions upstream.
- wb_fwd_pending = (state==WAIT) && latched wreg.
- An instruction held in WAIT/DRAIN is never flushed: it has already passed the commit point.
- Reset (asynchronous):
  - state=EMPTY, ebuf_valid=0.
  - All latched fields and all outputs are 0, except data_rready=1 and wb_allowin=1.
- Reset mid-WAIT or mid-DRAIN abandons the load; the memory side is reset by the same signal.
- A response arriving with ebuf full and state not WAIT/DRAIN is held off by data_rready=0.

Decomposition:
- Shared header gets the load-size codes (LS_BYTE/LS_HALF/LS_WORD) and the 2-bit state encodings.
- One natural sub-module: load_align, purely combinational (data, a, size, signed → extended word).

Test Plan:
- Live addu, accept in cycle 5, reorder_data=0x1234 → cycle 6: rf_wen=1, rf_waddr=ec_waddr, rf_wdata=0x1234; wb_allowin stays 1.
- lb signed, addr[1:0]=3, response 0x80FF_FF00 arrives 3 cycles after accept → WAIT, wb_fwd_pending=1 for 3 cycles, then rf_wdata=0xFFFF_FF80.
- Response 0x0000_ABCD arrives 2 cycles before an lhu (addr[1:0]=0) is accepted → ebuf holds it, data_rready=0 until accept; commit next cycle, rf_wdata=0x0000_ABCD.
- Load accepted with exc_oc=1 and ec_req_sent=1, no response yet → DRAIN, wb_allowin=0; response 0xDEAD_BEEF → EMPTY, no rf_wen ever asserted.
- eret accepted, live → exactly one cycle of wb_eret=1, rf_wen=0; write to $0 (ec_waddr=0, ec_wreg=1) → rf_wen=0.
- Reset asserted while in WAIT → outputs zero immediately; after release, state EMPTY, data_rready=1, a new non-load commits normally.
